multi_edge_detector: RTL and testbench
======================================

// Module: multi_edge_detector
// PURPOSE
//  - Multi-channel successor of the single-bit level-to-pulse converter.
//  - Per channel: synchronises an async level, debounces it, and emits one-cycle rise/fall pulses.
//  - Per-channel mode selects which edges raise o_event.
//  - Sits between board pushbuttons/switches and control FSMs; one instance serves a whole input bank.
// PARAMETERS
//  N_CH            4  number of independent channels (>=1)
//  SYNC_STAGES     2  synchroniser flops per channel (>=2)
//  DEBOUNCE_CYCLES 4  consecutive stable cycles needed to accept a new level (>=1; 1 = no filtering)
// PORTS
//  i_clk       in   1        clock; all logic on posedge
//  i_reset     in   1        synchronous, active-high reset
//  i_in        in   N_CH     raw asynchronous levels
//  i_mode      in   2*N_CH   edge_mode_t per channel; ch k at [2k+1:2k]
//  i_clr       in   N_CH     sticky-flag clear, per channel (used only with EDGE_DET_STICKY_EN)
//  o_level     out  N_CH     debounced level
//  o_rise_out  out  N_CH     1-cycle pulse on an accepted 0->1 transition
//  o_fall_out  out  N_CH     1-cycle pulse on an accepted 1->0 transition
//  o_event     out  N_CH     mode-qualified pulse
//  o_any_event out  1        OR of o_event
//  o_sticky    out  N_CH     latched event flags
// BEHAVIOUR
//  - Reset (synchronous): sync flops 0, FSM STABLE_LO, counter 0, all outputs 0.
//  - Reset mid-debounce discards the pending transition; no pulse is emitted.
//  - Per-channel FSM states: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO. Input s = synchroniser output.
//  - STABLE_LO, s=1: go to PEND_HI with cnt=1.
//    If DEBOUNCE_CYCLES==1, go directly to STABLE_HI with a rise pulse.
//  - PEND_HI, s=0: return to STABLE_LO, cnt=0, no pulse.
//  - PEND_HI, s=1: cnt++. When cnt reaches DEBOUNCE_CYCLES, go to STABLE_HI, cnt=0, rise pulse.
//  - STABLE_HI, PEND_LO: mirror image of the above; produce a fall pulse.
//  - o_level = 1 in STABLE_HI and PEND_LO; 0 otherwise. Registered.
//  - o_rise_out and o_fall_out are registered. Each is high exactly 1 cycle per accepted transition.
//    They are never high together on one channel.
//  - Latency (S=SYNC_STAGES, D=DEBOUNCE_CYCLES): take edge 1 as the first posedge sampling the new
//    i_in value. The pulse and the o_level change become visible after edge S+D.
//  - Glitch filtering: a level at s lasting fewer than D cycles produces no pulse and no o_level change.
//  - Counter width is $clog2(DEBOUNCE_CYCLES+1). It saturates at DEBOUNCE_CYCLES and never wraps.
//  - o_event[k] = (rise[k] & mode[k][0]) | (fall[k] & mode[k][1]).
//    This is combinational from registered pulses; a change to i_mode takes effect the same cycle.
//  - Modes: NONE=2'b00, RISE=2'b01, FALL=2'b10, BOTH=2'b11.
//  - o_any_event = |o_event.
//  - Reset released with i_in high: treated as a 0->1 transition; rise pulse after edge S+D.
//  - Channels are fully independent. Simultaneous events on several channels are all reported that cycle.
// CONFIGURATION
//  - Macro EDGE_DET_STICKY_EN defined:
//    - o_sticky[k] sets on o_event[k] and clears on i_clr[k]. Registered; 1-cycle latency.
//    - If set and clear occur in the same cycle, set wins.
//    - Reset clears all flags.
//  - Macro not defined:
//    - Ports remain present; o_sticky is tied to 0 and i_clr is ignored.
// STRUCTURE
//  - Package edge_det_pkg holds:
//    - typedef enum logic [1:0] edge_mode_t {NONE, RISE, FALL, BOTH};
//    - typedef enum logic [1:0] deb_state_t {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO}.
//  - Sub-module edge_det_chan: one channel (synchroniser, debounce FSM, counter, rise/fall registers).
//    Instantiated N_CH times by a generate loop.
//  - Mode gating, OR-reduce and sticky logic live in the top module.
// TESTING (N_CH=4, S=2, D=4 unless noted)
//  1. Reset with i_in=0, hold 10 cycles -> all outputs 0, o_level=4'b0000.
//  2. ch0 step 0->1 at edge 1 -> o_rise_out[0]=1 for exactly 1 cycle after edge 6, o_level[0]=1 from then.
//     Step back to 0 -> o_fall_out[0] pulse 6 edges later.
//  3. ch1 high for 3 cycles, then low -> no pulse, o_level[1] stays 0.
//     Repeat with a 4-cycle high -> rise pulse, then fall pulse.
//  4. Modes {BOTH,FALL,RISE,NONE} on ch3..0; toggle all inputs -> o_event:
//     - ch0 never fires;
//     - ch1 fires on rise only;
//     - ch2 fires on fall only;
//     - ch3 fires on both edges;
//     - o_any_event follows.
//  5. Assert i_reset while ch2 is in PEND_HI (cnt=2) -> no pulse, state STABLE_LO.
//     If i_in is still high after release, a rise pulse follows after edge 6.
//  6. With EDGE_DET_STICKY_EN: event on ch0 -> o_sticky[0]=1 and it holds.
//     i_clr[0] in the same cycle as a new event -> o_sticky[0] stays 1.
//     i_clr[0] alone -> o_sticky[0]=0 next cycle. Without the macro -> o_sticky always 0.

Source files
------------

// File: rtl/edge_det_pkg.sv
// ----------------------------------------------------------------------------
// edge_det_pkg
// Shared types for the multi-channel edge detector.
//   edge_mode_t : per-channel selection of which accepted edges raise o_event
//   deb_state_t : per-channel debounce FSM state
//   mode_gate() : applies an edge_mode_t to a rise/fall pulse pair
// ----------------------------------------------------------------------------
package edge_det_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        RISE = 2'b01,
        FALL = 2'b10,
        BOTH = 2'b11
    } edge_mode_t;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        PEND_HI   = 2'b01,
        STABLE_HI = 2'b10,
        PEND_LO   = 2'b11
    } deb_state_t;

    // Bit 0 of the mode enables rising edges, bit 1 enables falling edges.
    function automatic logic mode_gate(input logic rise, input logic fall,
                                       input logic [1:0] mode);
        return (rise & mode[0]) | (fall & mode[1]);
    endfunction

endpackage

// File: rtl/edge_det_chan.sv
// ----------------------------------------------------------------------------
// edge_det_chan
// One channel of the edge detector: synchroniser chain, debounce FSM with a
// saturating stability counter, and registered level / rise / fall outputs.
//
// state     | meaning
// ----------+------------------------------------------------------------
// STABLE_LO | accepted level 0, synchronised input agrees
// PEND_HI   | accepted level 0, input has been 1 for cnt cycles
// STABLE_HI | accepted level 1, synchronised input agrees
// PEND_LO   | accepted level 1, input has been 0 for cnt cycles
//
// Ports
//   i_clk    : clock, posedge
//   i_reset  : synchronous active-high reset
//   i_in     : raw asynchronous level
//   o_level  : debounced level (registered)
//   o_rise   : one-cycle pulse on an accepted 0->1 transition (registered)
//   o_fall   : one-cycle pulse on an accepted 1->0 transition (registered)
// ----------------------------------------------------------------------------
module edge_det_chan #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_in,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    import edge_det_pkg::*;

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    deb_state_t             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_in};
        end
    end

    // Saturating increment: the counter never wraps past CNT_MAX.
    assign cnt_inc = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE_LO: begin
                if (s) begin
                    // With a debounce length of one the first sample suffices.
                    if (CNT_MAX == CW'(1)) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = PEND_HI;
                        cnt_d   = CW'(1);
                    end
                end
            end
            PEND_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_MAX) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    if (CNT_MAX == CW'(1)) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = PEND_LO;
                        cnt_d   = CW'(1);
                    end
                end
            end
            PEND_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_MAX) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // Level is registered from the next state so it changes on the same
    // edge as the pulse.
    assign level_d = (state_d == STABLE_HI) || (state_d == PEND_LO);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

endmodule

// File: rtl/multi_edge_detector.sv
// ----------------------------------------------------------------------------
// multi_edge_detector
// Bank of N_CH independent synchronise/debounce/edge-pulse channels with
// per-channel edge-mode gating, an any-event summary and optional sticky flags.
//
// Build option: define EDGE_DET_STICKY_EN to enable the sticky event flags.
// Without it o_sticky is held at 0 and i_clr is ignored.
//
// Ports
//   i_clk       : clock, posedge
//   i_reset     : synchronous active-high reset
//   i_in        : raw asynchronous levels, one per channel
//   i_mode      : edge_mode_t per channel, channel k at [2k+1:2k]
//   i_clr       : per-channel sticky flag clear
//   o_level     : debounced levels
//   o_rise_out  : accepted 0->1 pulses
//   o_fall_out  : accepted 1->0 pulses
//   o_event     : mode-qualified pulses (combinational from registered pulses)
//   o_any_event : OR of o_event
//   o_sticky    : latched event flags
// ----------------------------------------------------------------------------
module multi_edge_detector #(
    parameter int N_CH            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [N_CH-1:0]   i_in,
    input  logic [2*N_CH-1:0] i_mode,
    input  logic [N_CH-1:0]   i_clr,
    output logic [N_CH-1:0]   o_level,
    output logic [N_CH-1:0]   o_rise_out,
    output logic [N_CH-1:0]   o_fall_out,
    output logic [N_CH-1:0]   o_event,
    output logic              o_any_event,
    output logic [N_CH-1:0]   o_sticky
);
    import edge_det_pkg::*;

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        edge_det_chan #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_in    (i_in[k]),
            .o_level (o_level[k]),
            .o_rise  (o_rise_out[k]),
            .o_fall  (o_fall_out[k])
        );
    end

    // Mode is applied combinationally so a mode change gates the current pulse.
    always_comb begin
        o_event = '0;
        for (int k = 0; k < N_CH; k++) begin
            o_event[k] = mode_gate(o_rise_out[k], o_fall_out[k], i_mode[2*k +: 2]);
        end
    end

    assign o_any_event = |o_event;

`ifdef EDGE_DET_STICKY_EN
    logic [N_CH-1:0] sticky_q;

    // Set has priority over clear.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= (sticky_q & ~i_clr) | o_event;
        end
    end

    assign o_sticky = sticky_q;
`else
    logic unused_clr;
    assign unused_clr = ^i_clr;
    assign o_sticky   = '0;
`endif

endmodule

// File: tb/tb_multi_edge_detector.sv
module tb_multi_edge_detector;
    localparam int N_CH = 4;
    localparam int S    = 2;
    localparam int D    = 4;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic [N_CH-1:0]   i_in;
    logic [2*N_CH-1:0] i_mode;
    logic [N_CH-1:0]   i_clr;
    logic [N_CH-1:0]   o_level, o_rise_out, o_fall_out, o_event, o_sticky;
    logic              o_any_event;

    multi_edge_detector #(
        .N_CH(N_CH), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_in(i_in), .i_mode(i_mode),
        .i_clr(i_clr), .o_level(o_level), .o_rise_out(o_rise_out),
        .o_fall_out(o_fall_out), .o_event(o_event),
        .o_any_event(o_any_event), .o_sticky(o_sticky)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per channel, a delay line of past input samples, the
    // accepted level and a run length of samples disagreeing with it.
    bit m_hist  [N_CH][S];
    int m_run   [N_CH];
    bit m_lvl   [N_CH];
    bit m_rise  [N_CH];
    bit m_fall  [N_CH];
    bit m_sticky[N_CH];

    function automatic bit m_event(int k);
        return (m_rise[k] && i_mode[2*k]) || (m_fall[k] && i_mode[2*k+1]);
    endfunction

    task automatic model_update();
        bit s, ev;
        for (int k = 0; k < N_CH; k++) begin
            if (i_reset) begin
                for (int j = 0; j < S; j++) m_hist[k][j] = 1'b0;
                m_run[k] = 0; m_lvl[k] = 0; m_rise[k] = 0; m_fall[k] = 0;
                m_sticky[k] = 0;
            end else begin
                ev = m_event(k);
`ifdef EDGE_DET_STICKY_EN
                m_sticky[k] = ev || (m_sticky[k] && !i_clr[k]);
`else
                m_sticky[k] = 1'b0;
`endif
                s = m_hist[k][S-1];
                m_rise[k] = 0;
                m_fall[k] = 0;
                if (s != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] >= D) begin
                        m_lvl[k] = s;
                        m_run[k] = 0;
                        if (s) m_rise[k] = 1; else m_fall[k] = 1;
                    end
                end else begin
                    m_run[k] = 0;
                end
                for (int j = S-1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
                m_hist[k][0] = i_in[k];
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [N_CH-1:0] e_lvl, e_r, e_f, e_ev, e_st;
        for (int k = 0; k < N_CH; k++) begin
            e_lvl[k] = m_lvl[k];
            e_r[k]   = m_rise[k];
            e_f[k]   = m_fall[k];
            e_ev[k]  = m_event(k);
            e_st[k]  = m_sticky[k];
        end
        chk("model_level", 32'(o_level), 32'(e_lvl));
        chk("model_rise",  32'(o_rise_out), 32'(e_r));
        chk("model_fall",  32'(o_fall_out), 32'(e_f));
        chk("model_event", 32'(o_event), 32'(e_ev));
        chk("model_any",   32'(o_any_event), 32'(|e_ev));
        chk("model_sticky", 32'(o_sticky), 32'(e_st));
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge i_clk);
        model_update();
        #1;
        compare_model();
    endtask

    typedef struct {
        logic in0;
        logic exp_level;
        logic exp_rise;
        logic exp_fall;
    } vec_t;
    vec_t tbl[16];

    int ev_cnt[N_CH];
    int any_cnt;
    int cnt_a;
    logic rise_seen;
    logic lvl_seen;

    initial begin
        // Step table for channel 0: high for 8 edges, then low for 8 edges.
        for (int r = 0; r < 16; r++) begin
            if (r < 8) begin
                tbl[r].in0 = 1'b1; tbl[r].exp_level = (r >= 5);
                tbl[r].exp_rise = (r == 5); tbl[r].exp_fall = 1'b0;
            end else begin
                tbl[r].in0 = 1'b0; tbl[r].exp_level = ((r - 8) < 5);
                tbl[r].exp_rise = 1'b0; tbl[r].exp_fall = ((r - 8) == 5);
            end
        end

        i_reset = 1'b1; i_in = '0; i_mode = 8'hFF; i_clr = '0;
        repeat (3) step();

        // Test 1: idle after reset.
        i_reset = 1'b0;
        repeat (10) step();
        chk("reset_level", 32'(o_level), 32'h0);
        chk("reset_pulses", 32'({o_rise_out, o_fall_out, o_event}), 32'h0);
        chk("reset_any_sticky", 32'({o_any_event, o_sticky}), 32'h0);

        // Test 2: table-driven step on channel 0, all modes BOTH.
        for (int r = 0; r < 16; r++) begin
            i_in[0] = tbl[r].in0;
            step();
            chk("tbl_level", 32'(o_level[0]), 32'(tbl[r].exp_level));
            chk("tbl_rise",  32'(o_rise_out[0]), 32'(tbl[r].exp_rise));
            chk("tbl_fall",  32'(o_fall_out[0]), 32'(tbl[r].exp_fall));
            chk("tbl_event", 32'(o_event[0]), 32'(tbl[r].exp_rise | tbl[r].exp_fall));
        end
        repeat (4) step();

        // Test 3: 3-cycle glitch on ch1 is filtered, 4-cycle high is accepted.
        cnt_a = 0; lvl_seen = 0;
        i_in[1] = 1'b1; repeat (3) step();
        i_in[1] = 1'b0;
        repeat (12) begin
            step();
            if (o_rise_out[1]) cnt_a++;
            if (o_level[1]) lvl_seen = 1;
        end
        chk("glitch3_rise", 32'(cnt_a), 32'd0);
        chk("glitch3_level", 32'(lvl_seen), 32'd0);
        cnt_a = 0; any_cnt = 0;
        i_in[1] = 1'b1; repeat (4) begin step(); if (o_rise_out[1]) cnt_a++; if (o_fall_out[1]) any_cnt++; end
        i_in[1] = 1'b0;
        repeat (12) begin step(); if (o_rise_out[1]) cnt_a++; if (o_fall_out[1]) any_cnt++; end
        chk("high4_rise", 32'(cnt_a), 32'd1);
        chk("high4_fall", 32'(any_cnt), 32'd1);

        // Test 4: modes {BOTH,FALL,RISE,NONE} on ch3..0 with all inputs toggled.
        i_mode = {2'b11, 2'b10, 2'b01, 2'b00};
        for (int k = 0; k < N_CH; k++) ev_cnt[k] = 0;
        any_cnt = 0;
        i_in = 4'hF;
        repeat (10) begin
            step();
            for (int k = 0; k < N_CH; k++) if (o_event[k]) ev_cnt[k]++;
            if (o_any_event) any_cnt++;
        end
        i_in = 4'h0;
        repeat (10) begin
            step();
            for (int k = 0; k < N_CH; k++) if (o_event[k]) ev_cnt[k]++;
            if (o_any_event) any_cnt++;
        end
        chk("mode_none_ch0", 32'(ev_cnt[0]), 32'd0);
        chk("mode_rise_ch1", 32'(ev_cnt[1]), 32'd1);
        chk("mode_fall_ch2", 32'(ev_cnt[2]), 32'd1);
        chk("mode_both_ch3", 32'(ev_cnt[3]), 32'd2);
        chk("mode_any", 32'(any_cnt), 32'd2);

        // Test 5: reset while ch2 is pending, input still high afterwards.
        i_mode = 8'hFF;
        i_in[2] = 1'b1;
        rise_seen = 0;
        repeat (4) begin step(); if (o_rise_out[2]) rise_seen = 1; end
        i_reset = 1'b1;
        step(); if (o_rise_out[2]) rise_seen = 1;
        chk("rst_pend_no_pulse", 32'(rise_seen), 32'd0);
        chk("rst_pend_level", 32'(o_level[2]), 32'd0);
        i_reset = 1'b0;
        repeat (5) begin step(); if (o_rise_out[2]) rise_seen = 1; end
        chk("rst_release_early", 32'(rise_seen), 32'd0);
        step();
        chk("rst_release_rise", 32'(o_rise_out[2]), 32'd1);
        step();
        chk("rst_release_one_cycle", 32'(o_rise_out[2]), 32'd0);
        i_in[2] = 1'b0;
        repeat (10) step();

        // Test 6: sticky flag on ch0 (expected values depend on the build).
        i_in[0] = 1'b1;
        repeat (6) step();
        chk("sticky_event_now", 32'(o_event[0]), 32'd1);
        step();
`ifdef EDGE_DET_STICKY_EN
        chk("sticky_set", 32'(o_sticky[0]), 32'd1);
`else
        chk("sticky_off_set", 32'(o_sticky[0]), 32'd0);
`endif
        repeat (3) step();
`ifdef EDGE_DET_STICKY_EN
        chk("sticky_hold", 32'(o_sticky[0]), 32'd1);
`else
        chk("sticky_off_hold", 32'(o_sticky[0]), 32'd0);
`endif
        i_clr[0] = 1'b1; step(); i_clr[0] = 1'b0;
        chk("sticky_clear", 32'(o_sticky[0]), 32'd0);
        i_in[0] = 1'b0;
        repeat (6) step();
        chk("sticky_fall_event", 32'(o_event[0]), 32'd1);
        i_clr[0] = 1'b1; step(); i_clr[0] = 1'b0;
`ifdef EDGE_DET_STICKY_EN
        chk("sticky_set_wins", 32'(o_sticky[0]), 32'd1);
`else
        chk("sticky_off_set_wins", 32'(o_sticky[0]), 32'd0);
`endif
        repeat (4) step();

        // Randomised phase checked against the model every cycle.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N_CH; k++) begin
                if ($urandom_range(0, 5) == 0) i_in[k] = ~i_in[k];
            end
            if ($urandom_range(0, 30) == 0) i_mode = 8'($urandom());
            i_clr   = ($urandom_range(0, 7) == 0) ? 4'($urandom()) : 4'h0;
            i_reset = ($urandom_range(0, 199) == 0);
            step();
        end
        i_reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
